// File: rtl/seg_scan_if.sv
// Display-side bundle of seg_scan_ctrl: buffer/length writes, scan outputs and ROM lookup.
// master = UI/board side, slave = the scan controller.
interface seg_scan_if #(
    parameter int DIGITS    = 4,
    parameter int MSG_DEPTH = 16
);
    localparam int AW = $clog2(MSG_DEPTH);

    logic              en;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [5:0]        wr_char;
    logic              len_we;
    logic [AW:0]       len_data;
    logic [DIGITS-1:0] dp;
    logic [5:0]        char_addr;
    logic [7:0]        char_seg;
    logic [7:0]        seg;
    logic [DIGITS-1:0] an;
    logic              scrolling;

    modport master (
        output en, wr_en, wr_addr, wr_char, len_we, len_data, dp, char_seg,
        input  char_addr, seg, an, scrolling
    );

    modport slave (
        input  en, wr_en, wr_addr, wr_char, len_we, len_data, dp, char_seg,
        output char_addr, seg, an, scrolling
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan controller with a small character buffer.
// Define SEG_SCROLL_EN to scroll messages longer than the display.
module seg_scan_ctrl #(
    parameter int DIGITS        = 4,
    parameter int MSG_DEPTH     = 16,
    parameter int SCAN_DIV      = 50000,
    parameter int SCROLL_FRAMES = 64
) (
    input logic       clk,
    input logic       rst_n,
    seg_scan_if.slave bus
);
    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(DIGITS);
    localparam int PW = $clog2(SCAN_DIV);

    localparam logic [PW-1:0]     PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]     DIG_LAST = DW'(DIGITS - 1);
    localparam logic [LW-1:0]     DEPTH_L  = LW'(MSG_DEPTH);
    localparam logic [LW-1:0]     DIGITS_L = LW'(DIGITS);
    localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);
    localparam logic [5:0]        BLANK    = 6'd10;

    logic [5:0]        msg_buf_r [MSG_DEPTH];
    logic [LW-1:0]     len_r;
    logic [PW-1:0]     presc_r;
    logic [DW-1:0]     digit_r;
    logic              adv_r;
    logic [5:0]        char_addr_r;
    logic [DW-1:0]     dig_d1_r;
    logic              en_d1_r;
    logic [7:0]        seg_r;
    logic [DIGITS-1:0] an_r;
    logic              scrolling_r;

    logic              tick_s;
    logic              wrap_s;
    logic              long_s;
    logic [AW-1:0]     offset_s;
    logic              scroll_act_s;
    logic [LW-1:0]     idx_s;
    logic [5:0]        code_s;

    assign tick_s = bus.en && (presc_r == PRE_LAST);
    assign wrap_s = tick_s && (digit_r == DIG_LAST);
    assign long_s = (len_r > DIGITS_L);

`ifdef SEG_SCROLL_EN
    localparam int FW = $clog2(SCROLL_FRAMES + 1);
    localparam logic [FW-1:0] FR_LAST = FW'(SCROLL_FRAMES - 1);

    logic [AW-1:0] offset_r;
    logic [FW-1:0] frame_r;

    // Scroll offset steps once every SCROLL_FRAMES frames; a length write restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_r <= '0;
            frame_r  <= '0;
        end else if (bus.len_we || !long_s) begin
            offset_r <= '0;
            frame_r  <= '0;
        end else if (wrap_s) begin
            if (frame_r == FR_LAST) begin
                frame_r  <= '0;
                offset_r <= (({1'b0, offset_r} + LW'(1)) == len_r) ? '0 : offset_r + AW'(1);
            end else begin
                frame_r <= frame_r + FW'(1);
            end
        end
    end

    assign offset_s     = offset_r;
    assign scroll_act_s = long_s && bus.en;
`else
    assign offset_s     = '0;
    assign scroll_act_s = 1'b0;
`endif

    // Character code for the current digit; offset < len so one wrap-subtract is enough.
    always_comb begin
        idx_s  = {1'b0, offset_s} + LW'(digit_r);
        code_s = BLANK;
        if (long_s) begin
            if (idx_s >= len_r) begin
                idx_s = idx_s - len_r;
            end else begin
                idx_s = idx_s;
            end
            code_s = msg_buf_r[idx_s[AW-1:0]];
        end else if (LW'(digit_r) < len_r) begin
            code_s = msg_buf_r[AW'(digit_r)];
        end else begin
            code_s = BLANK;
        end
    end

    // Message buffer write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                msg_buf_r[i] <= BLANK;
            end
        end else if (bus.wr_en) begin
            msg_buf_r[bus.wr_addr] <= bus.wr_char;
        end
    end

    // Message length, clamped to the buffer depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r <= '0;
        end else if (bus.len_we) begin
            len_r <= (bus.len_data > DEPTH_L) ? DEPTH_L : bus.len_data;
        end
    end

    // Slot prescaler and digit index; adv_r marks the cycle right after an index change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= '0;
            digit_r <= '0;
            adv_r   <= 1'b1;
        end else if (tick_s) begin
            presc_r <= '0;
            digit_r <= (digit_r == DIG_LAST) ? '0 : digit_r + DW'(1);
            adv_r   <= 1'b1;
        end else begin
            presc_r <= bus.en ? presc_r + PW'(1) : presc_r;
            adv_r   <= 1'b0;
        end
    end

    // Read stage: one ROM lookup per slot, so a same-cycle write shows next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_addr_r <= BLANK;
            dig_d1_r    <= '0;
            en_d1_r     <= 1'b0;
        end else begin
            en_d1_r <= bus.en;
            if (adv_r) begin
                char_addr_r <= code_s;
                dig_d1_r    <= digit_r;
            end
        end
    end

    // Pin stage: seg and an share dig_d1_r so they always name the same digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r       <= 8'h00;
            an_r        <= '1;
            scrolling_r <= 1'b0;
        end else begin
            scrolling_r <= scroll_act_s;
            if (bus.en && en_d1_r) begin
                seg_r <= bus.char_seg | {7'b0000000, bus.dp[dig_d1_r]};
                an_r  <= ~(AN_ONE << dig_d1_r);
            end else begin
                seg_r <= 8'h00;
                an_r  <= '1;
            end
        end
    end

    assign bus.char_addr = char_addr_r;
    assign bus.seg       = seg_r;
    assign bus.an        = an_r;
    assign bus.scrolling = scrolling_r;
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the multi-digit 7-segment display. It holds a small message buffer of 6-bit character codes and walks the digits one at a time. For each digit it presents the code on `char_addr` to the character-set ROM, takes the returned 8-bit pattern on `char_seg`, and drives the registered `seg`/`an` pins. It sits between the note/UI logic that writes the buffer and the board's display pins.

## Interface
- `DIGITS`, 4: number of physical digits (2..8).
- `MSG_DEPTH`, 16: message buffer entries (power of two, ≥ `DIGITS`).
- `SCAN_DIV`, 50000: clk cycles per digit slot (≥ 2).
- `SCROLL_FRAMES`, 64: full scan frames per scroll step (used only with `SEG_SCROLL_EN`).
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `en` in 1: display enable; 0 blanks the pins and freezes all counters.
- `wr_en` in 1: buffer write strobe.
- `wr_addr` in log2(MSG_DEPTH): buffer entry to write.
- `wr_char` in 6: character code to write (0–36 valid; 10 = blank).
- `len_we` in 1: message-length write strobe.
- `len_data` in log2(MSG_DEPTH)+1: new message length.
- `dp` in DIGITS: per-digit decimal point; `dp[d]` ORs into `seg[0]` for digit d.
- `char_addr` out 6: code to the character ROM, registered.
- `char_seg` in 8: ROM pattern {a,b,c,d,e,f,g,dp}, combinational from `char_addr`.
- `seg` out 8: segment drive, active-high, registered.
- `an` out DIGITS: digit enables, active-low, one-cold, registered.
- `scrolling` out 1: high while the scroll offset is advancing (`len` > `DIGITS`, scroll compiled in, `en`=1).

## Operation
- Reset values:
  - all buffer entries = 10; `len` = 0; digit index = 0; prescaler, frame counter and offset = 0.
  - `char_addr` = 10, `seg` = 8'h00, `an` = all ones, `scrolling` = 0.
- Buffer write: always accepted, no backpressure. `buf[wr_addr] <= wr_char` on `wr_en`. Codes > 36 are stored as-is; the ROM returns blank for them.
- Length write: on `len_we`, `len <= min(len_data, MSG_DEPTH)`.
  - The offset and frame counter clear in the same cycle.
  - The prescaler and digit index are not disturbed.
- Prescaler: counts 0..SCAN_DIV-1 while `en`=1. At the terminal count, the digit index advances d → d+1, wrapping DIGITS-1 → 0. A wrap ends a frame.
- Character select for digit d, with idx = offset + d:
  - If `len` > `DIGITS`: if idx ≥ `len`, idx = idx − `len` (a single subtract suffices because offset < `len`). Code = `buf[idx]`.
  - Otherwise: code = `buf[d]` if d < `len`, else 10.
  - If `len` = 0: every digit is blank.
- Digit d drives `an[d]` = 0. Digit 0 is the leftmost digit and shows the first character.
- `en`=0: `an` = all ones and `seg` = 0 from the next cycle. Counters hold. Buffer and length writes still take effect.
- Write/read collision: a write to the entry being read in the same cycle gives the old value to `char_addr`. The new value appears on the next read.

## Timing
- Cycle T: the digit index changes.
- Cycle T+1: `char_addr` updates to the new code.
- Cycle T+2: `seg` (= `char_seg` | {7'b0, `dp[d]`}) and `an` update together. `seg` and `an` never disagree on the digit.
- Each digit is lit for exactly `SCAN_DIV` cycles. Frame period = `DIGITS`×`SCAN_DIV` cycles.
- Rising edge of `en`: the first update on the pins appears 2 cycles later, with the held digit index.
- Asynchronous reset mid-scan: all outputs go to reset values immediately. Operation restarts at digit 0, with the prescaler at 0, after `rst_n` rises.

## Configuration
- `SEG_SCROLL_EN` defined:
  - At a frame wrap where the frame counter = `SCROLL_FRAMES`−1, offset <= (offset+1 == `len`) ? 0 : offset+1, and the frame counter clears.
  - Otherwise the frame counter increments at each frame wrap.
  - This applies only while `len` > `DIGITS`; otherwise the offset is held at 0.
- `SEG_SCROLL_EN` undefined:
  - No frame counter and offset ≡ 0.
  - Messages longer than `DIGITS` show their first `DIGITS` characters.
  - `scrolling` is tied to 0.

## Test plan
Bench parameters: DIGITS=4, SCAN_DIV=4, SCROLL_FRAMES=2, with the real character-set ROM attached.
- Reset: hold `rst_n`=0 and release → `an`=4'b1111, `seg`=8'h00, `char_addr`=10. The first lit digit, 2 cycles after the first slot boundary, shows `an`=4'b1110, `seg`=8'h00 (blank).
- Static: write codes 1,2,3,4 to entries 0–3, `len`=4 → in order, (`an`=1110, `seg`=8'h60), (1101, 8'hDA), (1011, 8'hF2), (0111, 8'h66). Each is held 4 cycles.
- Short message and dp: `len`=2, `dp`=4'b0010 → digit 1 shows `seg`=8'hDB. Digits 2 and 3 show 8'h00.
- Scroll (`SEG_SCROLL_EN`): codes 0..5, `len`=6 → after 2 frames digit 0 shows code 1 (8'h60). After 12 frames digit 0 shows code 0 again (8'hFC), and digit 3 shows code 3 at offset 0. `scrolling`=1 throughout.
- Collision and len rewrite: write entry 0 on the cycle its read occurs → the old pattern shows for that slot and the new one in the next frame. `len_we` mid-scroll → offset returns to 0 on the next read.
- Enable: drop `en` for 10 cycles mid-slot → `an`=1111 from the next cycle, and the slot resumes with its remaining count when `en` rises. Assert `rst_n`=0 asynchronously between clock edges → outputs reset immediately.
